// File: rtl/csc_pkg.sv
// Shared mode encoding, coefficient tables and pipeline constants for the
// colour-space converter.
package csc_pkg;

  typedef enum logic [1:0] {
    MODE_RGB2YCC_601 = 2'd0,
    MODE_RGB2YCC_709 = 2'd1,
    MODE_YCC2RGB_601 = 2'd2,
    MODE_BYPASS      = 2'd3
  } csc_mode_e;

  localparam int LATENCY = 3;

  // Q.8 coefficients indexed [mode][output channel][input channel].
  // Y-to-RGB and bypass rows use 256 (= 1.0) so every mode shares one datapath.
  localparam int COEF_TAB [4][3][3] = '{
    '{'{ 77,  150,   29}, '{-43,  -85,  128}, '{128, -107,  -21}},
    '{'{ 54,  183,   19}, '{-29,  -99,  128}, '{128, -116,  -12}},
    '{'{256,    0,  359}, '{256,  -88, -183}, '{256,  454,    0}},
    '{'{256,    0,    0}, '{  0,  256,    0}, '{  0,    0,  256}}
  };

  function automatic logic chroma_offset(input csc_mode_e m, input int ch);
    return ((m == MODE_RGB2YCC_601) || (m == MODE_RGB2YCC_709)) && (ch != 0);
  endfunction

  function automatic logic centered_chroma(input csc_mode_e m);
    return m == MODE_YCC2RGB_601;
  endfunction

endpackage

// File: rtl/csc_dot3.sv
// Registered three-term signed dot product with half-up rounding constant
// folded into the second register stage.
module csc_dot3
  import csc_pkg::*;
#(
  parameter int A_W    = 9,
  parameter int C_W    = 10,
  parameter int RND_SH = 8
) (
  input  logic                     sys_clk,
  input  logic signed [A_W-1:0]    a0,
  input  logic signed [A_W-1:0]    a1,
  input  logic signed [A_W-1:0]    a2,
  input  logic signed [C_W-1:0]    c0,
  input  logic signed [C_W-1:0]    c1,
  input  logic signed [C_W-1:0]    c2,
  output logic signed [A_W+C_W-1:0] sum_p1
);

  localparam int S_W = A_W + C_W;
  localparam logic signed [S_W-1:0] HALF = S_W'(2 ** (RND_SH - 1));

  logic signed [S_W-1:0] prod0_p0, prod1_p0, prod2_p0;

  function automatic logic signed [S_W-1:0] round_half_up(input logic signed [S_W-1:0] s);
    return s + HALF;
  endfunction

  // stage p0: products
  always_ff @(posedge sys_clk) begin
    prod0_p0 <= S_W'(a0) * S_W'(c0);
    prod1_p0 <= S_W'(a1) * S_W'(c1);
    prod2_p0 <= S_W'(a2) * S_W'(c2);
  end

  // stage p1: rounded sum
  always_ff @(posedge sys_clk) begin
    sum_p1 <= round_half_up(prod0_p0 + prod1_p0 + prod2_p0);
  end

endmodule

// File: rtl/csc_pipe.sv
// Three-stage colour-space converter (RGB<->YCbCr, bypass); the mode is
// latched per frame on vsync rise and travels with each pixel.
module csc_pipe
  import csc_pkg::*;
#(
  parameter int         DATA_W       = 8,
  parameter int         COEF_FRAC    = 8,
  parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [1:0]        cfg_mode,
  input  logic              per_img_vsync,
  input  logic              per_img_href,
  input  logic [DATA_W-1:0] per_img_ch0,
  input  logic [DATA_W-1:0] per_img_ch1,
  input  logic [DATA_W-1:0] per_img_ch2,
  output logic              post_img_vsync,
  output logic              post_img_href,
  output logic [DATA_W-1:0] post_img_ch0,
  output logic [DATA_W-1:0] post_img_ch1,
  output logic [DATA_W-1:0] post_img_ch2,
  output logic [1:0]        act_mode
);

  localparam int A_W = DATA_W + 1;
  localparam int C_W = COEF_FRAC + 2;
  localparam int S_W = A_W + C_W;
  localparam csc_mode_e DEF = csc_mode_e'(DEFAULT_MODE);
  localparam logic signed [A_W-1:0] MID_A = A_W'(2 ** (DATA_W - 1));
  localparam logic signed [S_W-1:0] MID_S = S_W'(2 ** (DATA_W - 1));
  localparam logic signed [S_W-1:0] MAX_S = S_W'(2 ** DATA_W - 1);

  logic      vsync_d;
  logic      vsync_rise;
  csc_mode_e mode_act;
  csc_mode_e mode_cur;

  logic      vld_p0, vld_p1, vld_p2;
  logic      vs_p0, vs_p1, vs_p2;
  csc_mode_e mode_p0, mode_p1, mode_p2;

  logic signed [A_W-1:0] opd  [3];
  logic signed [C_W-1:0] coef [3][3];
  logic signed [S_W-1:0] sum0_p1, sum1_p1, sum2_p1;
  logic [DATA_W-1:0]     ch0_p2, ch1_p2, ch2_p2;

  function automatic logic [DATA_W-1:0] shift_sat(input logic signed [S_W-1:0] s,
                                                  input logic add_mid);
    logic signed [S_W-1:0] v;
    v = s >>> COEF_FRAC;
    if (add_mid) v = v + MID_S;
    if (v[S_W-1]) return '0;
    if (v > MAX_S) return '1;
    return v[DATA_W-1:0];
  endfunction

  // A pixel arriving in the same cycle as the vsync rise already uses the new mode.
  assign vsync_rise = per_img_vsync & ~vsync_d;
  assign mode_cur   = vsync_rise ? csc_mode_e'(cfg_mode) : mode_act;

  always_comb begin
    opd[0] = signed'({1'b0, per_img_ch0});
    opd[1] = signed'({1'b0, per_img_ch1});
    opd[2] = signed'({1'b0, per_img_ch2});
    if (centered_chroma(mode_cur)) begin
      opd[1] = opd[1] - MID_A;
      opd[2] = opd[2] - MID_A;
    end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        coef[r][c] = C_W'(COEF_TAB[mode_cur][r][c]);
  end

  csc_dot3 #(.A_W(A_W), .C_W(C_W), .RND_SH(COEF_FRAC)) u_dot_ch0 (
    .sys_clk (sys_clk),
    .a0      (opd[0]),
    .a1      (opd[1]),
    .a2      (opd[2]),
    .c0      (coef[0][0]),
    .c1      (coef[0][1]),
    .c2      (coef[0][2]),
    .sum_p1  (sum0_p1)
  );

  csc_dot3 #(.A_W(A_W), .C_W(C_W), .RND_SH(COEF_FRAC)) u_dot_ch1 (
    .sys_clk (sys_clk),
    .a0      (opd[0]),
    .a1      (opd[1]),
    .a2      (opd[2]),
    .c0      (coef[1][0]),
    .c1      (coef[1][1]),
    .c2      (coef[1][2]),
    .sum_p1  (sum1_p1)
  );

  csc_dot3 #(.A_W(A_W), .C_W(C_W), .RND_SH(COEF_FRAC)) u_dot_ch2 (
    .sys_clk (sys_clk),
    .a0      (opd[0]),
    .a1      (opd[1]),
    .a2      (opd[2]),
    .c0      (coef[2][0]),
    .c1      (coef[2][1]),
    .c2      (coef[2][2]),
    .sum_p1  (sum2_p1)
  );

  // Input edge detector tracks vsync through reset, so a vsync already high at release is no rise.
  always_ff @(posedge sys_clk) begin
    vsync_d <= per_img_vsync;
  end

  // stages p0..p2: valid, sync and mode travel alongside the datapath
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      mode_act <= DEF;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      vs_p0    <= 1'b0;
      vs_p1    <= 1'b0;
      vs_p2    <= 1'b0;
      mode_p0  <= DEF;
      mode_p1  <= DEF;
      mode_p2  <= DEF;
    end else begin
      if (vsync_rise) mode_act <= csc_mode_e'(cfg_mode);
      vld_p0  <= per_img_href;
      vs_p0   <= per_img_vsync;
      mode_p0 <= mode_cur;
      vld_p1  <= vld_p0;
      vs_p1   <= vs_p0;
      mode_p1 <= mode_p0;
      vld_p2  <= vld_p1;
      vs_p2   <= vs_p1;
      mode_p2 <= mode_p1;
    end
  end

  // stage p2: shift, chroma offset, clamp
  always_ff @(posedge sys_clk) begin
    ch0_p2 <= shift_sat(sum0_p1, chroma_offset(mode_p1, 0));
    ch1_p2 <= shift_sat(sum1_p1, chroma_offset(mode_p1, 1));
    ch2_p2 <= shift_sat(sum2_p1, chroma_offset(mode_p1, 2));
  end

  assign post_img_vsync = vs_p2;
  assign post_img_href  = vld_p2;
  assign post_img_ch0   = vld_p2 ? ch0_p2 : '0;
  assign post_img_ch1   = vld_p2 ? ch1_p2 : '0;
  assign post_img_ch2   = vld_p2 ? ch2_p2 : '0;
  assign act_mode       = mode_p2;

endmodule

// File: tb/tb_csc_pipe.sv
// Randomized and directed bench for csc_pipe against an arithmetic reference
// model of the colour conversions.
`timescale 1ns/1ps
module tb_csc_pipe;
  import csc_pkg::*;

  localparam int         DW       = 8;
  localparam int         MAXV     = (1 << DW) - 1;
  localparam logic [1:0] DEF_MODE = 2'd1;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [1:0]    cfg_mode;
  logic          per_img_vsync, per_img_href;
  logic [DW-1:0] per_img_ch0, per_img_ch1, per_img_ch2;
  logic          post_img_vsync, post_img_href;
  logic [DW-1:0] post_img_ch0, post_img_ch1, post_img_ch2;
  logic [1:0]    act_mode;

  csc_pipe #(.DATA_W(DW), .COEF_FRAC(8), .DEFAULT_MODE(DEF_MODE)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .cfg_mode       (cfg_mode),
    .per_img_vsync  (per_img_vsync),
    .per_img_href   (per_img_href),
    .per_img_ch0    (per_img_ch0),
    .per_img_ch1    (per_img_ch1),
    .per_img_ch2    (per_img_ch2),
    .post_img_vsync (post_img_vsync),
    .post_img_href  (post_img_href),
    .post_img_ch0   (post_img_ch0),
    .post_img_ch1   (post_img_ch1),
    .post_img_ch2   (post_img_ch2),
    .act_mode       (act_mode)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: conversion equations with integer arithmetic.
  function automatic int rnd8(input int s);
    return (s + 128) >>> 8;
  endfunction

  function automatic int clip(input int v);
    return (v < 0) ? 0 : ((v > MAXV) ? MAXV : v);
  endfunction

  task automatic model(input int m, input int a, input int b, input int c,
                       output int o0, output int o1, output int o2);
    int h;
    h = 1 << (DW - 1);
    case (m)
      0: begin
        o0 = rnd8(77*a + 150*b + 29*c);
        o1 = rnd8(-43*a - 85*b + 128*c) + h;
        o2 = rnd8(128*a - 107*b - 21*c) + h;
      end
      1: begin
        o0 = rnd8(54*a + 183*b + 19*c);
        o1 = rnd8(-29*a - 99*b + 128*c) + h;
        o2 = rnd8(128*a - 116*b - 12*c) + h;
      end
      2: begin
        o0 = a + rnd8(359*(c - h));
        o1 = a + rnd8(-88*(b - h) - 183*(c - h));
        o2 = a + rnd8(454*(b - h));
      end
      default: begin
        o0 = a; o1 = b; o2 = c;
      end
    endcase
    o0 = clip(o0); o1 = clip(o1); o2 = clip(o2);
  endtask

  typedef struct {
    int c0, c1, c2, m, cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   last_rst = -100;
  logic vs_samp [8];
  logic [1:0] model_mode;

  // Scoreboard bookkeeping: edge count, sampled vsync history, reset flush.
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    vs_samp[(cyc + 1) % 8] <= per_img_vsync;
    if (!sys_rst) begin
      last_rst <= cyc + 1;
      q.delete();
    end
  end

  always @(negedge sys_clk) begin
    logic exp_vs;
    exp_t e;
    if (cyc >= 3) begin
      exp_vs = (last_rst >= cyc - 2) ? 1'b0 : vs_samp[(cyc - 2) % 8];
      check("vsync_delay", post_img_vsync, exp_vs);
    end
    if (post_img_href === 1'b1) begin
      check("pixel_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("latency", cyc, e.cyc);
        check("ch0", post_img_ch0, e.c0);
        check("ch1", post_img_ch1, e.c1);
        check("ch2", post_img_ch2, e.c2);
        check("act_mode", act_mode, e.m);
      end
    end else begin
      check("href_low", post_img_href, 0);
      check("idle_zero", {post_img_ch0, post_img_ch1, post_img_ch2}, 0);
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_vsync(input logic v);
    if (v && !per_img_vsync && sys_rst) model_mode = cfg_mode;
    per_img_vsync = v;
  endtask

  function automatic int pick();
    case ($urandom_range(3))
      0:       return 0;
      1:       return MAXV;
      default: return int'($urandom_range(MAXV));
    endcase
  endfunction

  task automatic drive_pix(input int a, input int b, input int c);
    exp_t e;
    per_img_href = 1'b1;
    per_img_ch0  = DW'(a);
    per_img_ch1  = DW'(b);
    per_img_ch2  = DW'(c);
    model(int'(model_mode), a, b, c, e.c0, e.c1, e.c2);
    e.m   = int'(model_mode);
    e.cyc = cyc + LATENCY;
    q.push_back(e);
  endtask

  task automatic idle();
    per_img_href = 1'b0;
    per_img_ch0  = DW'($urandom_range(MAXV));
    per_img_ch1  = DW'($urandom_range(MAXV));
    per_img_ch2  = DW'($urandom_range(MAXV));
  endtask

  task automatic run_frame(input logic [1:0] mode, input int lines, input int ppl,
                           input int chg_line, input logic [1:0] chg_mode);
    cfg_mode = mode;
    set_vsync(1'b1);
    idle();
    step();
    step();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        if (l == chg_line && p == ppl / 2) cfg_mode = chg_mode;
        if ($urandom_range(7) == 0) begin
          idle();
          step();
        end
        drive_pix(pick(), pick(), pick());
        step();
      end
      idle();
      repeat (4) step();
    end
    set_vsync(1'b0);
    repeat (4) step();
  endtask

  task automatic directed(input string tag, input logic [1:0] mode,
                          input int a, input int b, input int c,
                          input int e0, input int e1, input int e2);
    cfg_mode = mode;
    set_vsync(1'b1);
    drive_pix(a, b, c);
    step();
    idle();
    step();
    step();
    check({tag, "_href"}, post_img_href, 1);
    check({tag, "_ch0"}, post_img_ch0, e0);
    check({tag, "_ch1"}, post_img_ch1, e1);
    check({tag, "_ch2"}, post_img_ch2, e2);
    set_vsync(1'b0);
    repeat (3) step();
  endtask

  task automatic reset_midline();
    cfg_mode = 2'd0;
    set_vsync(1'b1);
    step();
    for (int p = 0; p < 640; p++) begin
      if (p == 300) begin
        idle();
        sys_rst    = 1'b0;
        model_mode = DEF_MODE;
        step();
        check("rst_href", post_img_href, 0);
        check("rst_data", {post_img_ch0, post_img_ch1, post_img_ch2}, 0);
        check("rst_act_mode", act_mode, DEF_MODE);
        sys_rst = 1'b1;
      end
      drive_pix(pick(), pick(), pick());
      step();
    end
    idle();
    repeat (4) step();
    set_vsync(1'b0);
    repeat (4) step();
  endtask

  initial begin
    sys_rst       = 1'b0;
    cfg_mode      = 2'd0;
    per_img_vsync = 1'b0;
    model_mode    = DEF_MODE;
    idle();
    repeat (4) step();
    check("reset_href", post_img_href, 0);
    check("reset_vsync", post_img_vsync, 0);
    check("reset_data", {post_img_ch0, post_img_ch1, post_img_ch2}, 0);
    check("reset_act_mode", act_mode, DEF_MODE);
    sys_rst = 1'b1;
    step();

    directed("white601", 2'd0, 255, 255, 255, 255, 128, 128);
    directed("red601",   2'd0, 255,   0,   0,  77,  85, 255);
    directed("ycc2rgb",  2'd2, 255, 128, 255, 255, 164, 255);

    for (int m = 0; m < 4; m++) run_frame(2'(m), 4, 48, -1, 2'd0);

    // cfg_mode switched to bypass mid-frame, then a bypass frame
    run_frame(2'd0, 4, 48, 1, 2'd3);
    run_frame(2'd3, 2, 48, -1, 2'd0);

    reset_midline();
    run_frame(2'd2, 3, 64, -1, 2'd0);

    // vsync already high when reset releases: default mode must hold
    cfg_mode = 2'd2;
    sys_rst  = 1'b0;
    model_mode = DEF_MODE;
    set_vsync(1'b1);
    step();
    step();
    sys_rst = 1'b1;
    for (int p = 0; p < 32; p++) begin
      drive_pix(pick(), pick(), pick());
      step();
    end
    idle();
    repeat (4) step();
    set_vsync(1'b0);
    repeat (4) step();

    run_frame(2'd1, 8, 640, -1, 2'd0);
    run_frame(2'd0, 2, 640, -1, 2'd0);

    repeat (8) step();
    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
